// File: rtl/draw_if.sv
// Request/handshake and datapath-control bundle between the game FSM,
// the draw controller and the datapath.
interface draw_if;
  // Handshake: start is a request that is only accepted while busy is low;
  // once accepted busy stays high until the cycle after the one-cycle done
  // pulse. Requests while busy are dropped, not queued.
  logic       start;
  logic       isSprite;
  logic       clear;
  logic [4:0] memorySelIn;
  logic [3:0] xInitSelIn;
  logic [1:0] yInitSelIn;

  logic [4:0] memorySel;
  logic [3:0] xInitSel;
  logic [1:0] yInitSel;
  logic       xInitReset, yInitReset;
  logic       xInitLoad, yInitLoad;
  logic       xReset, yReset;
  logic       xStart, yStart;
  logic       xCountUp, yCountUp;
  logic       xLoad, yLoad;
  logic       xySel;
  logic       black;
  logic       addressScreenCounterReset, addressSpriteCounterReset;
  logic       screenCountLoad, spriteCountLoad;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, isSprite, clear, memorySelIn, xInitSelIn, yInitSelIn,
    input  memorySel, xInitSel, yInitSel, xInitReset, yInitReset,
           xInitLoad, yInitLoad, xReset, yReset, xStart, yStart,
           xCountUp, yCountUp, xLoad, yLoad, xySel, black,
           addressScreenCounterReset, addressSpriteCounterReset,
           screenCountLoad, spriteCountLoad, plot, busy, done
  );

  modport slave (
    input  start, isSprite, clear, memorySelIn, xInitSelIn, yInitSelIn,
    output memorySel, xInitSel, yInitSel, xInitReset, yInitReset,
           xInitLoad, yInitLoad, xReset, yReset, xStart, yStart,
           xCountUp, yCountUp, xLoad, yLoad, xySel, black,
           addressScreenCounterReset, addressSpriteCounterReset,
           screenCountLoad, spriteCountLoad, plot, busy, done
  );
endinterface

// File: rtl/draw_controller.sv
// Sequences one full-region draw (screen or sprite): load origins, prefetch
// ROM data for MEM_LAT cycles, then raster-scan with one plot per cycle.
module draw_controller #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int MEM_LAT  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  draw_if.slave      bus,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PREFETCH = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t     state_q;
  logic       sprite_q, clear_q;
  logic [7:0] col_q, row_q, col_d, row_d;
  logic [1:0] pf_q;
  logic [7:0] w_last, h_last;
  logic       run_done, enter_run, run_xcu, run_wrap;

  assign w_last      = sprite_q ? 8'(SPRITE_W - 1) : 8'(SCREEN_W - 1);
  assign h_last      = sprite_q ? 8'(SPRITE_H - 1) : 8'(SCREEN_H - 1);
  assign dbg_state_o = state_q;

  // col_d/row_d name the pixel plotted in the next cycle whenever enter_run is set.
  always_comb begin
    col_d = '0;
    row_d = '0;
    if (state_q == S_RUN) begin
      if (col_q == w_last) begin
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
        row_d = row_q;
      end
    end
    run_done  = (state_q == S_RUN) && (col_q == w_last) && (row_q == h_last);
    enter_run = ((state_q == S_PREFETCH) && (pf_q == 2'(MEM_LAT - 1))) ||
                ((state_q == S_RUN) && !run_done);
    run_xcu   = (col_d != w_last);
    run_wrap  = (col_d == w_last) && (row_d != h_last);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      sprite_q <= 1'b0;
      clear_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      pf_q     <= '0;
      bus.memorySel  <= '0;
      bus.xInitSel   <= '0;
      bus.yInitSel   <= '0;
      bus.xInitReset <= 1'b0;
      bus.yInitReset <= 1'b0;
      bus.xInitLoad  <= 1'b0;
      bus.yInitLoad  <= 1'b0;
      bus.xReset     <= 1'b0;
      bus.yReset     <= 1'b0;
      bus.xStart     <= 1'b0;
      bus.yStart     <= 1'b0;
      bus.xCountUp   <= 1'b0;
      bus.yCountUp   <= 1'b0;
      bus.xLoad      <= 1'b0;
      bus.yLoad      <= 1'b0;
      bus.xySel      <= 1'b0;
      bus.black      <= 1'b0;
      bus.addressScreenCounterReset <= 1'b0;
      bus.addressSpriteCounterReset <= 1'b0;
      bus.screenCountLoad <= 1'b0;
      bus.spriteCountLoad <= 1'b0;
      bus.plot <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.xInitReset <= 1'b0;
      bus.yInitReset <= 1'b0;
      bus.xInitLoad  <= 1'b0;
      bus.yInitLoad  <= 1'b0;
      bus.xReset     <= 1'b0;
      bus.yReset     <= 1'b0;
      bus.xStart     <= 1'b0;
      bus.yStart     <= 1'b0;
      bus.xCountUp   <= 1'b0;
      bus.yCountUp   <= 1'b0;
      bus.xLoad      <= 1'b0;
      bus.yLoad      <= 1'b0;
      bus.xySel      <= 1'b0;
      bus.black      <= 1'b0;
      bus.addressScreenCounterReset <= 1'b0;
      bus.addressSpriteCounterReset <= 1'b0;
      bus.screenCountLoad <= 1'b0;
      bus.spriteCountLoad <= 1'b0;
      bus.plot <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q       <= S_LOAD;
            sprite_q      <= bus.isSprite;
            clear_q       <= bus.clear;
            bus.memorySel <= bus.memorySelIn;
            bus.xInitSel  <= bus.xInitSelIn;
            bus.yInitSel  <= bus.yInitSelIn;
            bus.xInitLoad <= 1'b1;
            bus.yInitLoad <= 1'b1;
            bus.xReset    <= 1'b1;
            bus.yReset    <= 1'b1;
            bus.addressSpriteCounterReset <= bus.isSprite;
            bus.addressScreenCounterReset <= !bus.isSprite;
            bus.black     <= bus.clear;
            bus.busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q    <= S_PREFETCH;
          pf_q       <= '0;
          bus.xStart <= 1'b1;
          bus.yStart <= 1'b1;
          bus.xLoad  <= 1'b1;
          bus.yLoad  <= 1'b1;
          bus.spriteCountLoad <= sprite_q;
          bus.screenCountLoad <= !sprite_q;
          bus.black  <= clear_q;
          bus.busy   <= 1'b1;
        end
        S_PREFETCH: begin
          if (pf_q == 2'(MEM_LAT - 1)) begin
            state_q <= S_RUN;
          end else begin
            pf_q <= pf_q + 2'd1;
            bus.spriteCountLoad <= sprite_q;
            bus.screenCountLoad <= !sprite_q;
            bus.black <= clear_q;
            bus.busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (run_done) begin
            state_q  <= S_DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Controls for the pixel plotted next cycle; the x/y update it carries
      // moves the datapath onto the pixel after that one.
      if (enter_run) begin
        col_q        <= col_d;
        row_q        <= row_d;
        bus.plot     <= 1'b1;
        bus.xySel    <= 1'b1;
        bus.black    <= clear_q;
        bus.busy     <= 1'b1;
        bus.spriteCountLoad <= sprite_q;
        bus.screenCountLoad <= !sprite_q;
        bus.xCountUp <= run_xcu;
        bus.xLoad    <= run_xcu || run_wrap;
        bus.xStart   <= run_wrap;
        bus.yCountUp <= run_wrap;
        bus.yLoad    <= run_wrap;
      end
    end
  end

endmodule

// File: tb/tb_draw_controller.sv
// Bench for draw_controller: per-cycle expected control vectors derived from
// the draw timeline, plus a small x/y datapath model that checks pixel coordinates.
module tb_draw_controller;

  localparam int L = 2;

  localparam int B_DONE = 0, B_BUSY = 1, B_PLOT = 2, B_SPRCL = 3, B_SCRCL = 4;
  localparam int B_SPRRST = 5, B_SCRRST = 6, B_BLACK = 7, B_XYSEL = 8;
  localparam int B_YLOAD = 9, B_XLOAD = 10, B_YCU = 11, B_XCU = 12;
  localparam int B_YSTART = 13, B_XSTART = 14, B_YRESET = 15, B_XRESET = 16;
  localparam int B_YINITLOAD = 17, B_XINITLOAD = 18, B_YINITRESET = 19, B_XINITRESET = 20;

  logic       clk;
  logic       resetn;
  logic [2:0] dbg_state;

  draw_if bus();

  draw_controller #(.MEM_LAT(L)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] coord_q[$];
  logic [10:0] cur_sel;
  logic [10:0] idle_sel;
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected outputs for cycle offset k of a draw started at k=0.
  function automatic logic [31:0] exp_vec(int k, bit spr, bit clr, logic [10:0] sel);
    logic [31:0] v;
    int w, h, n, p, col, row;
    v = '0;
    v[31:21] = sel;
    w = spr ? 40 : 160;
    h = spr ? 40 : 120;
    n = w * h;
    if (k == 1) begin
      v[B_XINITLOAD] = 1'b1; v[B_YINITLOAD] = 1'b1;
      v[B_XRESET] = 1'b1;    v[B_YRESET] = 1'b1;
      v[spr ? B_SPRRST : B_SCRRST] = 1'b1;
      v[B_BLACK] = clr;      v[B_BUSY] = 1'b1;
    end else if (k >= 2 && k <= 1 + L) begin
      v[spr ? B_SPRCL : B_SCRCL] = 1'b1;
      v[B_BLACK] = clr;      v[B_BUSY] = 1'b1;
      if (k == 2) begin
        v[B_XSTART] = 1'b1; v[B_YSTART] = 1'b1;
        v[B_XLOAD] = 1'b1;  v[B_YLOAD] = 1'b1;
      end
    end else if (k >= 2 + L && k < 2 + L + n) begin
      p = k - 2 - L;
      col = p % w;
      row = p / w;
      v[B_PLOT] = 1'b1; v[spr ? B_SPRCL : B_SCRCL] = 1'b1;
      v[B_XYSEL] = 1'b1; v[B_BLACK] = clr; v[B_BUSY] = 1'b1;
      if (col < w - 1) begin
        v[B_XCU] = 1'b1; v[B_XLOAD] = 1'b1;
      end else if (row < h - 1) begin
        v[B_XSTART] = 1'b1; v[B_YCU] = 1'b1; v[B_XLOAD] = 1'b1; v[B_YLOAD] = 1'b1;
      end
    end else if (k == 2 + L + n) begin
      v[B_DONE] = 1'b1; v[B_BUSY] = 1'b1;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raises start with the given request in the current cycle (t0) and
  // queues every expected cycle through DONE; returns the DONE offset.
  task automatic begin_draw(input bit spr, input bit clr, input logic [4:0] msel,
                            input logic [3:0] xs, input logic [1:0] ys, output int last_k);
    logic [10:0] sel;
    int w, h;
    w = spr ? 40 : 160;
    h = spr ? 40 : 120;
    sel = {msel, xs, ys};
    bus.isSprite    = spr;
    bus.clear       = clr;
    bus.memorySelIn = msel;
    bus.xInitSelIn  = xs;
    bus.yInitSelIn  = ys;
    bus.start       = 1'b1;
    last_k = 2 + L + w * h;
    exp_q.push_back(exp_vec(0, spr, clr, cur_sel));
    for (int k = 1; k <= last_k; k++) exp_q.push_back(exp_vec(k, spr, clr, sel));
    for (int p = 0; p < w * h; p++)
      coord_q.push_back({16'(int'(xs) * 8 + p % w), 16'(int'(ys) * 20 + p / w)});
    cur_sel = sel;
  endtask

  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    exp_q.delete();
    coord_q.delete();
    cur_sel  = '0;
    idle_sel = '0;
    wait_cycles(cycles);
    resetn = 1'b1;
  endtask

  // ---------------- monitor + datapath model ----------------
  int mx = 0, my = 0, mxinit = 0, myinit = 0;

  always @(negedge clk) begin
    logic [31:0] act, exp;
    int nx, ny;
    act = '0;
    act[31:21] = {bus.memorySel, bus.xInitSel, bus.yInitSel};
    act[B_XINITRESET] = bus.xInitReset; act[B_YINITRESET] = bus.yInitReset;
    act[B_XINITLOAD] = bus.xInitLoad;   act[B_YINITLOAD] = bus.yInitLoad;
    act[B_XRESET] = bus.xReset;         act[B_YRESET] = bus.yReset;
    act[B_XSTART] = bus.xStart;         act[B_YSTART] = bus.yStart;
    act[B_XCU] = bus.xCountUp;          act[B_YCU] = bus.yCountUp;
    act[B_XLOAD] = bus.xLoad;           act[B_YLOAD] = bus.yLoad;
    act[B_XYSEL] = bus.xySel;           act[B_BLACK] = bus.black;
    act[B_SCRRST] = bus.addressScreenCounterReset;
    act[B_SPRRST] = bus.addressSpriteCounterReset;
    act[B_SCRCL] = bus.screenCountLoad; act[B_SPRCL] = bus.spriteCountLoad;
    act[B_PLOT] = bus.plot;             act[B_BUSY] = bus.busy;
    act[B_DONE] = bus.done;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      idle_sel = exp[31:21];
    end else begin
      exp = {idle_sel, 21'b0};
    end
    check("ctl", act, exp);

    if (bus.plot) begin
      if (coord_q.size() > 0) check("coord", {16'(mx), 16'(my)}, coord_q.pop_front());
      else check("plot_extra", 32'(bus.plot), 32'd0);
    end

    nx = mx;
    ny = my;
    if (bus.xReset) nx = 0;
    if (bus.yReset) ny = 0;
    if (bus.xLoad) nx = bus.xStart ? mxinit : mx + int'(bus.xCountUp);
    if (bus.yLoad) ny = bus.yStart ? myinit : my + int'(bus.yCountUp);
    if (bus.xInitLoad) mxinit = int'(bus.xInitSel) * 8;
    if (bus.yInitLoad) myinit = int'(bus.yInitSel) * 20;
    mx = nx;
    my = ny;
  end

  // ---------------- stimulus ----------------
  initial begin
    int e, e2;
    cur_sel  = '0;
    idle_sel = '0;
    bus.start = 1'b0; bus.isSprite = 1'b0; bus.clear = 1'b0;
    bus.memorySelIn = '0; bus.xInitSelIn = '0; bus.yInitSelIn = '0;
    resetn = 1'b0;
    wait_cycles(3);
    resetn = 1'b1;
    wait_cycles(2);

    // Sprite draw with a stray start (and changed selects) at t0+100.
    begin_draw(1'b1, 1'b0, 5'(3'($urandom_range(0, 7))), 4'd3, 2'd1, e);
    wait_cycles(1);
    bus.start = 1'b0;
    wait_cycles(99);
    bus.start = 1'b1;
    bus.isSprite = 1'b0;
    bus.clear = 1'b1;
    bus.memorySelIn = 5'd31;
    bus.xInitSelIn = 4'd15;
    bus.yInitSelIn = 2'd3;
    wait_cycles(1);
    bus.start = 1'b0;
    wait_cycles(e - 100);
    wait_cycles(3);

    // Full screen draw in black.
    begin_draw(1'b0, 1'b1, 5'(3'($urandom_range(0, 7))), 4'(3'($urandom_range(0, 7))),
               2'($urandom_range(0, 3)), e);
    wait_cycles(1);
    bus.start = 1'b0;
    wait_cycles(e);
    wait_cycles(2);

    // Reset mid-draw, then a fresh draw.
    begin_draw(1'b1, 1'b0, 5'd9, 4'd5, 2'd2, e);
    wait_cycles(1);
    bus.start = 1'b0;
    wait_cycles(499);
    do_reset(2);
    wait_cycles(2);
    begin_draw(1'b1, 1'b1, 5'd17, 4'd2, 2'd3, e);
    wait_cycles(1);
    bus.start = 1'b0;
    wait_cycles(e);
    wait_cycles(2);

    // start held high: back-to-back draws with one IDLE cycle between.
    begin_draw(1'b1, 1'b0, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)), e);
    wait_cycles(e + 1);
    begin_draw(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), e2);
    wait_cycles(1);
    bus.start = 1'b0;
    wait_cycles(e2);
    wait_cycles(2);

    // Random sprite requests with random idle gaps.
    for (int i = 0; i < 3; i++) begin
      begin_draw(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), e);
      wait_cycles(1);
      bus.start = 1'b0;
      bus.memorySelIn = 5'($urandom_range(0, 31));
      wait_cycles(e);
      wait_cycles($urandom_range(0, 3));
    end

    wait_cycles(3);
    check("exp_drain", 32'(exp_q.size()), 32'd0);
    check("coord_drain", 32'(coord_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
